// File: rtl/ram_port_arbiter.sv
// Arbiter for a single-port unified RAM shared by instruction fetch (IF) and the data port (D).
// Defining RAM_ARB_ALIGN_CHECK_EN turns misaligned granted requests into non-issued, zero-data completions.
module ram_port_arbiter #(
    parameter int RD_LATENCY   = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [29:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    output logic        busy,
    output logic        align_err
);

`ifdef RAM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_D      = 1'b1;
    localparam logic [1:0] LAT_INIT   = 2'(RD_LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t      state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic        owner_q, owner_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  streak_q, streak_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        align_err_q, align_err_d;
    logic        drop_q, drop_d;

    logic        done;
    logic        can_grant;
    logic        pick_if;
    logic        any_gnt;
    logic        rd_issue;
    logic        misaligned;
    logic [31:0] gnt_addr;
    logic [31:0] ret_data;

    always_comb begin
        // The completion cycle of a read counts as idle, so back-to-back reads need no bubble.
        done      = (state_q == S_WAIT) && (lat_q == 2'd0);
        can_grant = !reset && ((state_q == S_IDLE) || done);

        // Data wins a tie unless it has already starved a pending fetch for MAX_D_STREAK grants.
        pick_if   = if_req && (!d_req || (streak_q == STREAK_MAX));
        if_gnt    = can_grant && pick_if;
        d_gnt     = can_grant && d_req && !pick_if;
        any_gnt   = if_gnt || d_gnt;

        gnt_addr   = if_gnt ? if_addr : d_addr;
        misaligned = ALIGN_CHECK && (gnt_addr[1:0] != 2'b00);
        rd_issue   = if_gnt || (d_gnt && !d_we);

        ram_address = reset ? 30'd0 : (any_gnt ? gnt_addr[31:2] : addr_q);
        ram_data    = d_wdata;
        ram_wren    = d_gnt && d_we && !misaligned;

        // A misaligned read never reached the RAM, so it returns zero instead of ram_q.
        ret_data  = drop_q ? 32'h0 : ram_q;
        if_rvalid = !reset && done && (owner_q == OWN_IF);
        d_rvalid  = !reset && done && (owner_q == OWN_D);
        if_rdata  = reset ? 32'h0 : (if_rvalid ? ret_data : if_rdata_q);
        d_rdata   = reset ? 32'h0 : (d_rvalid ? ret_data : d_rdata_q);
        busy      = !reset && (state_q == S_WAIT) && !done;
        align_err = !reset && align_err_q;

        state_d = state_q;
        lat_d   = lat_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        if (any_gnt) begin
            addr_d = gnt_addr[31:2];
        end
        if (rd_issue) begin
            state_d = S_WAIT;
            lat_d   = LAT_INIT;
            owner_d = d_gnt ? OWN_D : OWN_IF;
            drop_d  = misaligned;
        end else if (done) begin
            state_d = S_IDLE;
        end else if (state_q == S_WAIT) begin
            lat_d = lat_q - 2'd1;
        end

        if (!if_req || if_gnt) begin
            streak_d = 4'd0;
        end else if (d_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end else begin
            streak_d = streak_q;
        end

        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        align_err_d = align_err_q || (any_gnt && misaligned);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_q       <= 2'd0;
            owner_q     <= OWN_IF;
            addr_q      <= 30'd0;
            streak_q    <= 4'd0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            align_err_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            streak_q    <= streak_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            align_err_q <= align_err_d;
            drop_q      <= drop_d;
        end
    end

endmodule
